// File: rtl/adder_measure_pkg.sv
// Shared types and defaults for the adder ring-oscillator measurement sequencer.
// Holds the FSM state encoding, default widths and the disabled-tap mask level.
package adder_measure_pkg;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_COUNT_W       = 16;
    localparam int DEF_WINDOW_W      = 32;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_SYNC_STAGES   = 2;

    // Tap-select masks are active-low: a 1 disables the tap.
    localparam logic MASK_OFF = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/adder_measure_ctrl_sync.sv
// Multi-flop synchronizer for the asynchronous ring output, followed by a
// one-flop rising-edge detector producing a single-cycle pulse.
module async_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/adder_measure_ctrl.sv
// Measurement sequencer: latches adder operands and tap masks, enables the ring
// for a programmed window and reports a saturating count of ring rising edges.
module adder_measure_ctrl
    import adder_measure_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int WINDOW_W      = DEF_WINDOW_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    cfg_a,
    input  logic [WIDTH-1:0]    cfg_b,
    input  logic [WIDTH-1:0]    cfg_ring_mask,
    input  logic [WIDTH-1:0]    cfg_ext_mask,
    input  logic [WINDOW_W-1:0] cfg_window,
    input  logic                chain_out,
    output logic [WIDTH-1:0]    a_input,
    output logic [WIDTH-1:0]    b_input,
    output logic [WIDTH-1:0]    a_input_ring_bit_b,
    output logic [WIDTH-1:0]    a_input_ext_bit_b,
    output logic                ring_en,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [COUNT_W-1:0]  ring_count
);

    localparam logic [WINDOW_W-1:0] ONE         = WINDOW_W'(1);
    localparam logic [WINDOW_W-1:0] SETTLE_LOAD = WINDOW_W'(SETTLE_CYCLES);
    localparam logic [WINDOW_W-1:0] DRAIN_LOAD  = WINDOW_W'(SYNC_STAGES + 1);

    state_t              state_q;
    state_t              state_d;
    logic [WINDOW_W-1:0] timer_q;
    logic [WINDOW_W-1:0] window_q;
    logic                accept;
    logic                timer_last;
    logic                counting;
    logic                rise;

    async_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .async_in (chain_out),
        .rise     (rise)
    );

    assign accept     = (state_q == IDLE) && start && !abort;
    assign timer_last = (timer_q == ONE);
    assign counting   = (state_q == RUN) || (state_q == DRAIN);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ring_en = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                if (timer_last) state_d = (window_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                ring_en = 1'b1;
                if (timer_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (timer_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

    // Single down-counter shared by the settle, run and drain phases; IDLE preloads settle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            timer_q <= '0;
        end else begin
            case (state_q)
                SETUP:   timer_q <= timer_last ? ((window_q == '0) ? DRAIN_LOAD : window_q)
                                               : timer_q - ONE;
                RUN:     timer_q <= timer_last ? DRAIN_LOAD : timer_q - ONE;
                DRAIN:   timer_q <= timer_q - ONE;
                default: timer_q <= SETTLE_LOAD;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            a_input            <= '0;
            b_input            <= '0;
            a_input_ring_bit_b <= {WIDTH{MASK_OFF}};
            a_input_ext_bit_b  <= {WIDTH{MASK_OFF}};
            window_q           <= '0;
        end else if (accept) begin
            a_input            <= cfg_a;
            b_input            <= cfg_b;
            a_input_ring_bit_b <= cfg_ring_mask;
            a_input_ext_bit_b  <= cfg_ext_mask;
            window_q           <= cfg_window;
        end
    end

    // Saturating edge counter; an edge arriving at all-ones is lost and flagged.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            ring_count <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            ring_count <= '0;
            overflow   <= 1'b0;
        end else if (counting && rise) begin
            if (&ring_count) begin
                overflow <= 1'b1;
            end else begin
                ring_count <= ring_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Self-checking bench for adder_measure_ctrl: scenario tasks with randomized
// operands and ring activity checked against an edge-counting reference model.
module tb_adder_measure_ctrl;

    localparam int WIDTH    = 32;
    localparam int COUNT_W  = 12;  // narrow counter so saturation is reachable in a short run
    localparam int WINDOW_W = 32;
    localparam int SETTLE   = 4;
    localparam int SYNC     = 2;
    localparam int CNT_MAX  = (1 << COUNT_W) - 1;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                chain_out = 1'b0;
    logic [WIDTH-1:0]    cfg_a = '0;
    logic [WIDTH-1:0]    cfg_b = '0;
    logic [WIDTH-1:0]    cfg_ring_mask = '0;
    logic [WIDTH-1:0]    cfg_ext_mask = '0;
    logic [WINDOW_W-1:0] cfg_window = '0;
    logic [WIDTH-1:0]    a_input;
    logic [WIDTH-1:0]    b_input;
    logic [WIDTH-1:0]    a_input_ring_bit_b;
    logic [WIDTH-1:0]    a_input_ext_bit_b;
    logic                ring_en;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [COUNT_W-1:0]  ring_count;

    int n_vec = 0;
    int n_err = 0;

    adder_measure_ctrl #(
        .WIDTH         (WIDTH),
        .COUNT_W       (COUNT_W),
        .WINDOW_W      (WINDOW_W),
        .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .wb_clk_i           (wb_clk_i),
        .wb_rst_n           (wb_rst_n),
        .start              (start),
        .abort              (abort),
        .cfg_a              (cfg_a),
        .cfg_b              (cfg_b),
        .cfg_ring_mask      (cfg_ring_mask),
        .cfg_ext_mask       (cfg_ext_mask),
        .cfg_window         (cfg_window),
        .chain_out          (chain_out),
        .a_input            (a_input),
        .b_input            (b_input),
        .a_input_ring_bit_b (a_input_ring_bit_b),
        .a_input_ext_bit_b  (a_input_ext_bit_b),
        .ring_en            (ring_en),
        .busy               (busy),
        .done               (done),
        .overflow           (overflow),
        .ring_count         (ring_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic randomize_cfg();
        cfg_a         = $urandom;
        cfg_b         = $urandom;
        cfg_ring_mask = $urandom;
        cfg_ext_mask  = $urandom;
    endtask

    // One full measurement. mode 0: chain toggles every 4 ring cycles, 1: every cycle, 2: random.
    // Model: count rising edges driven while ring_en is high, saturate at the counter maximum.
    task automatic run_measure(input int window, input int mode, input bit poke_start);
        logic [WIDTH-1:0] a, b, rm, em;
        logic             v;
        logic             chain_prev;
        int               exp_done, cyc, ring_cycles, first_ring, rises, exp_cnt;
        bit               exp_ovf, seen_done;
        randomize_cfg();
        a = cfg_a; b = cfg_b; rm = cfg_ring_mask; em = cfg_ext_mask;
        cfg_window = WINDOW_W'(window);
        chain_out  = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || ring_count !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL start_accept: busy=%b count=%0h ovf=%b, required busy=1 count=0 ovf=0",
                     busy, ring_count, overflow);
        end
        exp_done   = 1 + SETTLE + window + SYNC + 1;
        cyc        = 1;
        ring_cycles = 0;
        first_ring = -1;
        rises      = 0;
        chain_prev = 1'b0;
        seen_done  = 1'b0;
        while (!seen_done && cyc <= exp_done + 20) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end else begin
                n_vec++;
                if (a_input !== a || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL latched_a cycle %0d: a_input=%h busy=%b, required a_input=%h busy=1",
                             cyc, a_input, busy, a);
                end
                if (ring_en === 1'b1) begin
                    if (first_ring < 0) first_ring = cyc;
                    case (mode)
                        0:       v = ((ring_cycles / 4) % 2 == 0);
                        1:       v = (ring_cycles % 2 == 0);
                        default: v = 1'($urandom_range(0, 1));
                    endcase
                    if (v && !chain_prev) rises++;
                    chain_prev = v;
                    chain_out  = v;
                    ring_cycles++;
                end
                randomize_cfg();
                cfg_window = WINDOW_W'($urandom);
                start = (poke_start && ring_en === 1'b1 && ring_cycles == 3);
                tick();
                start = 1'b0;
                cyc++;
            end
        end
        exp_cnt = (rises > CNT_MAX) ? CNT_MAX : rises;
        exp_ovf = (rises > CNT_MAX);
        n_vec++;
        if (!seen_done) begin
            n_err++;
            $display("FAIL done_timeout window %0d: no done by cycle %0d, required at cycle %0d",
                     window, cyc, exp_done);
        end else begin
            if (cyc != exp_done) begin
                n_err++;
                $display("FAIL done_latency window %0d: done at cycle %0d, required %0d",
                         window, cyc, exp_done);
            end
            n_vec++;
            if (ring_count !== COUNT_W'(exp_cnt) || overflow !== exp_ovf) begin
                n_err++;
                $display("FAIL result window %0d: count=%0d ovf=%b, required count=%0d ovf=%b",
                         window, ring_count, overflow, exp_cnt, exp_ovf);
            end
            n_vec++;
            if (ring_cycles != window ||
                first_ring != ((window == 0) ? -1 : SETTLE + 1)) begin
                n_err++;
                $display("FAIL ring_window %0d: ring cycles=%0d first=%0d, required cycles=%0d first=%0d",
                         window, ring_cycles, first_ring, window, (window == 0) ? -1 : SETTLE + 1);
            end
            n_vec++;
            if (b_input !== b || a_input_ring_bit_b !== rm || a_input_ext_bit_b !== em) begin
                n_err++;
                $display("FAIL latched_bm: b=%h ring=%h ext=%h, required b=%h ring=%h ext=%h",
                         b_input, a_input_ring_bit_b, a_input_ext_bit_b, b, rm, em);
            end
            tick();
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || ring_count !== COUNT_W'(exp_cnt) || a_input !== a) begin
                n_err++;
                $display("FAIL after_done: done=%b busy=%b count=%0d a=%h, required 0 0 %0d %h",
                         done, busy, ring_count, a_input, exp_cnt, a);
            end
        end
        chain_out = 1'b0;
        repeat (SYNC + 2) tick();
    endtask

    task automatic test_reset(input bit mid_run);
        int  k;
        bit  saw_done;
        if (mid_run) begin
            randomize_cfg();
            cfg_window = 50;
            start = 1'b1;
            tick();
            start = 1'b0;
            k = 0;
            for (int c = 0; c < 40 && k < 12; c++) begin
                if (ring_en === 1'b1) begin
                    chain_out = ((k / 4) % 2 == 0);
                    k++;
                end
                tick();
            end
            n_vec++;
            if (ring_en !== 1'b1) begin
                n_err++;
                $display("FAIL reset_pre_run: ring_en=%b, required 1", ring_en);
            end
        end
        wb_rst_n = 1'b0;
        tick();
        n_vec++;
        if (ring_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
            ring_count !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: ring_en=%b busy=%b done=%b ovf=%b count=%0h, required all 0",
                     ring_en, busy, done, overflow, ring_count);
        end
        n_vec++;
        if (a_input !== '0 || b_input !== '0 ||
            a_input_ring_bit_b !== {WIDTH{1'b1}} || a_input_ext_bit_b !== {WIDTH{1'b1}}) begin
            n_err++;
            $display("FAIL reset_data: a=%h b=%h ring=%h ext=%h, required 0 0 ffffffff ffffffff",
                     a_input, b_input, a_input_ring_bit_b, a_input_ext_bit_b);
        end
        wb_rst_n  = 1'b1;
        chain_out = 1'b0;
        saw_done  = 1'b0;
        repeat (8) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_vec++;
        if (saw_done || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_quiet: done seen=%b busy=%b, required 0 0", saw_done, busy);
        end
    endtask

    task automatic test_window80();
        run_measure(80, 0, 1'b0);
    endtask

    task automatic test_window0();
        run_measure(0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_measure(40, 2, 1'b1);
    endtask

    task automatic test_abort();
        int k;
        bit aborted, saw_done;
        randomize_cfg();
        cfg_window = 100;
        start = 1'b1;
        tick();
        start   = 1'b0;
        k       = 0;
        aborted = 1'b0;
        for (int c = 0; c < 200 && !aborted; c++) begin
            if (ring_en === 1'b1) begin
                chain_out = ((k / 4) % 2 == 0);
                if (k == 19) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
                k++;
            end
            tick();
            abort = 1'b0;
        end
        n_vec++;
        if (!aborted) begin
            n_err++;
            $display("FAIL abort_reach: ring cycles=%0d, required 20", k);
        end
        n_vec++;
        if (busy !== 1'b0 || ring_en !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b ring_en=%b done=%b, required 0 0 0", busy, ring_en, done);
        end
        n_vec++;
        if (ring_count !== COUNT_W'(3) || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL abort_partial: count=%0d ovf=%b, required 3 0", ring_count, overflow);
        end
        chain_out = 1'b0;
        saw_done  = 1'b0;
        repeat (12) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL abort_no_done: done seen=1, required 0");
        end
        run_measure(0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_measure($urandom_range(0, 60), 2, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        run_measure(1, 1, 1'b0);
        run_measure(5, 1, 1'b0);
        run_measure(2, 0, 1'b0);
    endtask

    task automatic test_saturate();
        run_measure(10000, 1, 1'b0);
        run_measure(6, 1, 1'b0);
    endtask

    initial begin
        test_reset(1'b0);
        test_window80();
        test_window0();
        test_start_ignored();
        test_abort();
        test_reset(1'b1);
        test_random();
        test_back_to_back();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_measure_ctrl.md
Name: adder_measure_ctrl

Overview:
- Measurement sequencer for the instrumented adder ring-oscillator datapath.
- Latches operands and ring/external tap masks, drives them onto the adder, and enables the ring for a programmed window of wb_clk_i cycles.
- Counts rising edges of the asynchronous chain_out, then reports a saturating count with a done pulse.
- Sits between the LA/Wishbone-facing wrapper registers and the instrumented adder instance.

Parameters:
- WIDTH, 32, adder operand and mask width
- COUNT_W, 16, ring edge counter width
- WINDOW_W, 32, measurement window counter width
- SETTLE_CYCLES, 4, cycles operands are held before ring enable
- SYNC_STAGES, 2, flops in the chain_out synchronizer (min 2)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_n  in  1  synchronous active-low reset
- start  in  1  begin measurement; sampled only in IDLE
- abort  in  1  cancel measurement; returns to IDLE
- cfg_a  in  WIDTH  operand A
- cfg_b  in  WIDTH  operand B
- cfg_ring_mask  in  WIDTH  ring tap select; active-low bits as consumed by adder
- cfg_ext_mask  in  WIDTH  external tap select; active-low
- cfg_window  in  WINDOW_W  RUN length in cycles
- chain_out  in  1  asynchronous ring output from adder
- a_input  out  WIDTH  to adder
- b_input  out  WIDTH  to adder
- a_input_ring_bit_b  out  WIDTH  to adder
- a_input_ext_bit_b  out  WIDTH  to adder
- ring_en  out  1  ring oscillation enable
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when result valid
- overflow  out  1  count saturated during last run
- ring_count  out  COUNT_W  result; held until next accepted start

Behaviour:
- Reset: reset is synchronous and active-low (wb_rst_n low at a wb_clk_i edge). All outputs 0, except a_input_ring_bit_b and a_input_ext_bit_b, which reset to all-ones (all taps disabled). Synchronizer flops cleared. State IDLE.
- Reset mid-operation: same values at the next edge; no done pulse is issued.
- FSM states: IDLE, SETUP, RUN, DRAIN, DONE.
- IDLE:
  - When start=1 and abort=0, latch all cfg_* inputs. Clear ring_count and overflow. Go to SETUP. busy=1 from the next cycle.
  - start while busy is ignored.
- SETUP:
  - Drive the latched values onto the adder outputs with ring_en=0, for exactly SETTLE_CYCLES cycles.
  - Then go to RUN. If the latched window is 0, go straight to DRAIN instead.
- RUN:
  - ring_en=1 for exactly cfg_window cycles, using a down-counter loaded with cfg_window.
  - Leave RUN when the counter reaches 1.
- Edge counting:
  - chain_out passes through a SYNC_STAGES-flop synchronizer, then a one-flop edge detector.
  - Each detected rising edge increments ring_count in RUN and DRAIN.
  - At all-ones, ring_count holds and overflow sets (sticky until the next start).
- DRAIN:
  - ring_en=0 for SYNC_STAGES+1 cycles, so edges still in flight in the synchronizer are counted. Then go to DONE.
- DONE:
  - done=1 for one cycle, then IDLE. ring_count and overflow are stable from the cycle done asserts.
  - Adder outputs keep the latched values until the next start.
- Abort:
  - In any non-IDLE state, abort=1 gives IDLE next cycle with ring_en=0 and no done pulse.
  - ring_count keeps its partial value; overflow also keeps its value.
  - abort has priority over start and over normal transitions.
- Latency:
  - start to first ring_en=1 is SETTLE_CYCLES+1 cycles.
  - start to done is 1 + SETTLE_CYCLES + cfg_window + SYNC_STAGES + 1 cycles.
- cfg_* inputs may change freely while busy; only the latched copies are used.

Decomposition:
- Shared package adder_measure_pkg holds:
  - FSM state enum (IDLE, SETUP, RUN, DRAIN, DONE)
  - default widths
  - the reset value of the active-low masks (all-ones)
- One sub-module: async_edge_sync, the SYNC_STAGES synchronizer plus rising-edge pulse, parameterised by stage count.

Test Plan:
- Reset with wb_rst_n low during RUN -> next edge: ring_en=0, busy=0, done=0, ring_count=0, both masks 0xFFFFFFFF.
- cfg_window=80, SETTLE_CYCLES=4; chain_out toggled synchronously every 4 cycles (rising edge every 8) only while ring_en=1 -> done exactly 88 cycles after start, ring_count=10, overflow=0.
- cfg_window=0 -> ring_en never asserts, done 8 cycles after start, ring_count=0.
- COUNT_W=16, cfg_window=200000, chain_out toggling every cycle -> ring_count=0xFFFF, overflow=1, done on schedule.
- abort asserted in cycle 20 of RUN -> IDLE next cycle, ring_en=0, no done pulse. A following start clears ring_count to 0.
- start pulsed again during RUN with different cfg_a -> ignored; a_input keeps the originally latched value until done.
